wbc_intercon_rr: RTL and testbench
==================================

Name: wbc_intercon_rr

Overview:
- Parametrised WISHBONE classic shared-bus interconnect: NM masters, NS slaves, with generic data and address widths.
- Registered round-robin arbiter; the grant is locked for the whole CYC of the granted master.
- Base/mask address decode with a table-driven slave map.
- Internal error responses for unmapped addresses and for slave timeout.
- Sits between the control masters (PCI, TURF, housekeeping, VIO) and the register/RAM slaves. Also exposes grant and fault status for the debug ILA.

Parameters:
NM, 4, number of masters (1..8)
NS, 4, number of slaves (1..16)
AW, 20, address width
DW, 32, data width (multiple of 8); SW = DW/8 select width
SLAVE_BASE, {20'h30000,20'h20000,20'h10000,20'h00000}, NS*AW packed bases, slave 0 in LSBs
SLAVE_MASK, {4{20'h0FFFF}}, NS*AW packed masks; mask bits are passed through to the slave, ~mask bits are compared against base
TIMEOUT, 256, cycles STB may wait for ACK/ERR/RTY before internal ERR; 0 disables

Ports:
clk_i  in  1  bus clock
rst_i  in  1  asynchronous reset, active high
m_cyc_i  in  NM  master CYC
m_stb_i  in  NM  master STB
m_we_i  in  NM  master WE
m_adr_i  in  NM*AW  master address, master 0 in LSBs
m_dat_i  in  NM*DW  master write data
m_sel_i  in  NM*SW  master byte selects
m_ack_o  out  NM  ACK to master
m_err_o  out  NM  ERR to master
m_rty_o  out  NM  RTY to master
m_dat_o  out  NM*DW  read data (all masters see muxed slave data)
s_cyc_o  out  NS  slave CYC
s_stb_o  out  NS  slave STB
s_we_o  out  NS  slave WE
s_adr_o  out  NS*AW  slave address = adr & mask
s_dat_o  out  NS*DW  write data
s_sel_o  out  NS*SW  byte selects
s_ack_i  in  NS  slave ACK
s_err_i  in  NS  slave ERR
s_rty_i  in  NS  slave RTY
s_dat_i  in  NS*DW  slave read data
gnt_o  out  NM  registered one-hot grant
decode_err_o  out  1  one-cycle pulse on unmapped-address error
timeout_o  out  1  one-cycle pulse on timeout error

Behaviour:
- Reset (async assert, sync-free release) clears:
  - gnt_o = 0, arbiter to IDLE, RR pointer = 0;
  - timeout counter = 0, internal err flag = 0;
  - all s_* cyc/stb/we = 0, all m_ack/err/rty = 0, both status pulses = 0.
- Reset mid-transfer drops the grant immediately; the master's cycle is abandoned with no ack.
- Arbiter states:
  - IDLE: gnt = 0. If any m_cyc_i, then at the next edge grant the first requester at or above the pointer (wrapping) and go to BUSY. Arbitration latency is 1 cycle.
  - BUSY: grant held while the granted m_cyc_i = 1; other requests are ignored.
  - At an edge where the granted m_cyc_i = 0: pointer = granted index + 1 (mod NM). If other requests are present, grant the next one directly (stay BUSY, no idle cycle); otherwise go to IDLE.
- Bus mux: cyc/stb/we/adr/dat/sel are taken from the granted master only. With no grant, all slave strobes are 0.
- Decode:
  - sel[k] = ((adr & ~MASK[k]) == BASE[k]).
  - With overlapping matches the lowest k wins (one-hot after priority).
  - s_cyc_o[k] = cyc & sel[k]; likewise stb and we.
  - adr/dat/sel are broadcast to all slaves (adr masked per slave).
- Response mux: ack/err/rty/dat come from the selected slave. They are routed only to the granted master, combinationally, with zero added latency.
- Unmapped address (no sel, stb = 1):
  - No slave strobed.
  - Internal ERR asserted to the granted master on the cycle after STB is seen, for one cycle.
  - decode_err_o pulses in the same cycle.
  - m_dat_o = 0.
- Timeout:
  - Counter increments each cycle that stb = 1 and no ack/err/rty is present.
  - Counter clears on any response, on stb = 0, or on a grant change.
  - When the count reaches TIMEOUT-1: one-cycle internal ERR to the master, timeout_o pulse, counter clears. Slave strobes stay as driven by the master.
  - A slave ack arriving in the same cycle as the timeout ERR: the slave ack wins, no ERR, no pulse.
- Internal ERR is OR'd into m_err_o; it never coincides with ack.
- Single-master configuration (NM = 1): grant simply follows cyc with 1-cycle latency.

Test Plan:
- Reset, then m0 write adr 0x10004 data 0xDEADBEEF; slave 1 acks 2 cycles after stb -> gnt_o = 0001 one cycle after cyc; s_cyc_o = 0010, s_adr_o[1] = 0x00004; m_ack_o[0] one cycle; no other strobes.
- m0, m1, m3 assert cyc together and hold for 3 single transfers each -> grant order 0,1,3 then back to 0; no idle cycle between grants; grant never changes mid-cyc.
- m2 reads adr 0x70000 -> no s_stb_o; m_err_o[2] and decode_err_o high exactly 1 cycle, on the cycle after stb; m_dat_o = 0.
- TIMEOUT = 16, m1 reads slave 3, which never responds -> m_err_o[1] and timeout_o pulse on the 16th stb cycle. Repeat with the slave acking on that exact cycle -> ack only, no pulse.
- rst_i asserted mid-burst while m0 is granted -> gnt_o, s_cyc_o, m_ack_o go 0 asynchronously. After release, the first request is granted from pointer 0.

Source files
------------

// File: rtl/wbc_intercon_rr_if.sv
// Bus bundle for the wbc_intercon_rr shared-bus interconnect.
// Carries the master-facing request/response signals and the slave-facing
// strobe/response signals. Every vector is packed with index 0 in the LSBs.
//   slave  modport : the view the interconnect takes (requests in, responses out)
//   master modport : the view the surrounding masters/slaves take (the opposite)
interface wbc_intercon_rr_if #(
    parameter int unsigned NM = 4,
    parameter int unsigned NS = 4,
    parameter int unsigned AW = 20,
    parameter int unsigned DW = 32
);
    localparam int unsigned SW = DW / 8;

    // master side
    logic [NM-1:0]    m_cyc_i;
    logic [NM-1:0]    m_stb_i;
    logic [NM-1:0]    m_we_i;
    logic [NM*AW-1:0] m_adr_i;
    logic [NM*DW-1:0] m_dat_i;
    logic [NM*SW-1:0] m_sel_i;
    logic [NM-1:0]    m_ack_o;
    logic [NM-1:0]    m_err_o;
    logic [NM-1:0]    m_rty_o;
    logic [NM*DW-1:0] m_dat_o;

    // slave side
    logic [NS-1:0]    s_cyc_o;
    logic [NS-1:0]    s_stb_o;
    logic [NS-1:0]    s_we_o;
    logic [NS*AW-1:0] s_adr_o;
    logic [NS*DW-1:0] s_dat_o;
    logic [NS*SW-1:0] s_sel_o;
    logic [NS-1:0]    s_ack_i;
    logic [NS-1:0]    s_err_i;
    logic [NS-1:0]    s_rty_i;
    logic [NS*DW-1:0] s_dat_i;

    modport slave (
        input  m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        output m_ack_o, m_err_o, m_rty_o, m_dat_o,
        output s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        input  s_ack_i, s_err_i, s_rty_i, s_dat_i
    );

    modport master (
        output m_cyc_i, m_stb_i, m_we_i, m_adr_i, m_dat_i, m_sel_i,
        input  m_ack_o, m_err_o, m_rty_o, m_dat_o,
        input  s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o,
        output s_ack_i, s_err_i, s_rty_i, s_dat_i
    );
endinterface

// File: rtl/wbc_intercon_rr.sv
// WISHBONE classic shared-bus interconnect, NM masters to NS slaves.
// A registered round-robin arbiter grants one master for the whole of its CYC;
// the granted master's request is decoded against a base/mask slave table and
// the selected slave's response is routed back combinationally. Unmapped
// addresses and unanswered strobes get an internal ERR.
// Ports:
//   clk_i, rst_i  : bus clock, asynchronous active-high reset
//   bus           : request/response bundle (wbc_intercon_rr_if.slave)
//   gnt_o         : registered one-hot grant
//   decode_err_o  : one-cycle pulse when an unmapped address is errored
//   timeout_o     : one-cycle pulse when a slave timeout is errored
module wbc_intercon_rr #(
    parameter int unsigned      NM         = 4,
    parameter int unsigned      NS         = 4,
    parameter int unsigned      AW         = 20,
    parameter int unsigned      DW         = 32,
    parameter logic [NS*AW-1:0] SLAVE_BASE = {20'h30000, 20'h20000, 20'h10000, 20'h00000},
    parameter logic [NS*AW-1:0] SLAVE_MASK = {4{20'h0FFFF}},
    parameter int unsigned      TIMEOUT    = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    wbc_intercon_rr_if.slave     bus,
    output logic [NM-1:0]        gnt_o,
    output logic                 decode_err_o,
    output logic                 timeout_o
);
    localparam int unsigned SW = DW / 8;
    localparam int unsigned IW = (NM > 1) ? $clog2(NM) : 1;
    localparam int unsigned KW = (NS > 1) ? $clog2(NS) : 1;
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e        state_q, state_d;
    logic [NM-1:0] gnt_q, gnt_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] gnt_idx;
    logic [IW-1:0] nxt_ptr;
    logic [IW-1:0] start;
    logic          gnt_cyc;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    // ---------------- arbiter ----------------
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (gnt_q[i]) gnt_idx = IW'(i);
        end
    end

    assign gnt_cyc = (|gnt_q) & bus.m_cyc_i[gnt_idx];
    assign nxt_ptr = (32'(gnt_idx) == NM - 1) ? '0 : gnt_idx + 1'b1;

    // First requester at or above start, wrapping. On release the granted
    // master's CYC is already low, so it is naturally skipped.
    always_comb begin
        logic [31:0] j;
        start      = (state_q == StIdle) ? ptr_q : nxt_ptr;
        pick_valid = 1'b0;
        pick_idx   = '0;
        j          = '0;
        for (int unsigned i = 0; i < NM; i++) begin
            j = (32'(start) + i) % NM;
            if (!pick_valid && bus.m_cyc_i[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    gnt_d           = '0;
                    gnt_d[pick_idx] = 1'b1;
                    state_d         = StBusy;
                end
            end
            StBusy: begin
                if (!gnt_cyc) begin
                    ptr_d = nxt_ptr;
                    gnt_d = '0;
                    if (pick_valid) begin
                        gnt_d[pick_idx] = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
        end
    end

    // ---------------- request mux ----------------
    logic          bus_cyc, bus_stb, bus_we;
    logic [AW-1:0] bus_adr;
    logic [DW-1:0] bus_dat;
    logic [SW-1:0] bus_sel;

    assign bus_cyc = gnt_cyc;
    assign bus_stb = gnt_cyc & bus.m_stb_i[gnt_idx];
    assign bus_we  = gnt_cyc & bus.m_we_i[gnt_idx];
    assign bus_adr = bus.m_adr_i[gnt_idx*AW +: AW];
    assign bus_dat = bus.m_dat_i[gnt_idx*DW +: DW];
    assign bus_sel = bus.m_sel_i[gnt_idx*SW +: SW];

    // ---------------- address decode ----------------
    logic [NS-1:0] sel_oh;
    logic [KW-1:0] sel_idx;
    logic          mapped;

    // Walk downwards so the lowest matching slave is the last one written.
    always_comb begin
        sel_oh  = '0;
        sel_idx = '0;
        mapped  = 1'b0;
        for (int k = int'(NS) - 1; k >= 0; k--) begin
            if ((bus_adr & ~SLAVE_MASK[k*AW +: AW]) == SLAVE_BASE[k*AW +: AW]) begin
                sel_idx = KW'(k);
                mapped  = 1'b1;
            end
        end
        if (mapped) sel_oh[sel_idx] = 1'b1;
    end

    always_comb begin
        bus.s_cyc_o = '0;
        bus.s_stb_o = '0;
        bus.s_we_o  = '0;
        bus.s_adr_o = '0;
        bus.s_dat_o = '0;
        bus.s_sel_o = '0;
        for (int k = 0; k < int'(NS); k++) begin
            bus.s_cyc_o[k]          = bus_cyc & sel_oh[k];
            bus.s_stb_o[k]          = bus_stb & sel_oh[k];
            bus.s_we_o[k]           = bus_we & sel_oh[k];
            bus.s_adr_o[k*AW +: AW] = bus_adr & SLAVE_MASK[k*AW +: AW];
            bus.s_dat_o[k*DW +: DW] = bus_dat;
            bus.s_sel_o[k*SW +: SW] = bus_sel;
        end
    end

    // ---------------- response mux ----------------
    logic          slv_ack, slv_err, slv_rty, slv_resp;
    logic [DW-1:0] rdat;
    logic          derr_q;
    logic          tmo_fire;
    logic          stb_mapped;

    assign slv_ack    = bus_cyc & mapped & bus.s_ack_i[sel_idx];
    assign slv_err    = bus_cyc & mapped & bus.s_err_i[sel_idx];
    assign slv_rty    = bus_cyc & mapped & bus.s_rty_i[sel_idx];
    assign slv_resp   = slv_ack | slv_err | slv_rty;
    assign rdat       = mapped ? bus.s_dat_i[sel_idx*DW +: DW] : '0;
    assign stb_mapped = bus_stb & mapped;

    // Unmapped strobe: ERR on the following cycle; the !derr_q term keeps a
    // master that is still holding STB in that cycle from re-triggering.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            derr_q <= 1'b0;
        end else begin
            derr_q <= bus_stb & ~mapped & ~derr_q;
        end
    end

    if (TIMEOUT > 0) begin : g_tmo
        logic [TW-1:0] tmo_q;

        // Combinational so a slave response in the same cycle suppresses it.
        assign tmo_fire = stb_mapped & ~slv_resp & (tmo_q == TW'(TIMEOUT - 1));

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                tmo_q <= '0;
            end else if (!stb_mapped || slv_resp || tmo_fire || (gnt_d != gnt_q)) begin
                tmo_q <= '0;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end else begin : g_no_tmo
        assign tmo_fire = 1'b0;
    end

    assign bus.m_ack_o  = gnt_q & {NM{slv_ack}};
    assign bus.m_err_o  = gnt_q & {NM{slv_err | derr_q | tmo_fire}};
    assign bus.m_rty_o  = gnt_q & {NM{slv_rty}};
    assign bus.m_dat_o  = {NM{rdat}};

    assign gnt_o        = gnt_q;
    assign decode_err_o = derr_q;
    assign timeout_o    = tmo_fire;
endmodule

// File: tb/tb_wbc_intercon_rr.sv
// Directed bench for wbc_intercon_rr: reset state, single write, round-robin
// ordering, unmapped-address error, timeout, and reset in mid-transfer.
module tb_wbc_intercon_rr;
    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 20;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NM-1:0] gnt;
    logic          derr;
    logic          tmo;

    int checks = 0;
    int errors = 0;

    // simple slave responders: ack arrives in stb cycle s_lat+1
    logic [NS-1:0] s_ack = '0;
    int            s_cnt[NS] = '{default: 0};
    int            s_lat[NS] = '{default: 1000};

    wbc_intercon_rr_if #(.NM(NM), .NS(NS), .AW(AW), .DW(DW)) bus();

    wbc_intercon_rr #(
        .NM      (NM),
        .NS      (NS),
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .bus          (bus),
        .gnt_o        (gnt),
        .decode_err_o (derr),
        .timeout_o    (tmo)
    );

    always #5 clk = ~clk;

    assign bus.s_ack_i = s_ack;
    assign bus.s_err_i = '0;
    assign bus.s_rty_i = '0;

    always @(posedge clk) begin
        for (int k = 0; k < NS; k++) begin
            if (!bus.s_stb_o[k] || s_ack[k]) begin
                s_ack[k] <= 1'b0;
                s_cnt[k] <= 0;
            end else begin
                if (s_cnt[k] + 1 == s_lat[k]) s_ack[k] <= 1'b1;
                s_cnt[k] <= s_cnt[k] + 1;
            end
        end
    end

    task automatic set_master(input int m, input logic c, input logic w,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.m_cyc_i[m]         = c;
        bus.m_stb_i[m]         = c;
        bus.m_we_i[m]          = w;
        bus.m_adr_i[m*AW +: AW] = a;
        bus.m_dat_i[m*DW +: DW] = d;
        bus.m_sel_i[m*SW +: SW] = c ? {SW{1'b1}} : {SW{1'b0}};
    endtask

    task automatic idle_all();
        for (int m = 0; m < NM; m++) set_master(m, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_all();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (bus.s_cyc_o !== 4'b0000 || bus.s_stb_o !== 4'b0000 || bus.s_we_o !== 4'b0000) begin
            errors++; $display("FAIL reset_s_strobes cyc=%b stb=%b we=%b exp=0", bus.s_cyc_o, bus.s_stb_o, bus.s_we_o); end
        checks++; if (bus.m_ack_o !== 4'b0000 || bus.m_err_o !== 4'b0000 || bus.m_rty_o !== 4'b0000) begin
            errors++; $display("FAIL reset_m_resp ack=%b err=%b rty=%b exp=0", bus.m_ack_o, bus.m_err_o, bus.m_rty_o); end
        checks++; if (derr !== 1'b0 || tmo !== 1'b0) begin
            errors++; $display("FAIL reset_pulses derr=%b tmo=%b exp=0", derr, tmo); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_idle_gnt got=%b exp=0000", gnt); end
    endtask

    task automatic test_single_write();
        int            ack_at;
        int            stray;
        logic [NM-1:0] ackv;
        s_lat[1] = 2;
        ack_at = 0; stray = 0; ackv = '0;
        set_master(0, 1'b1, 1'b1, 20'h10004, 32'hDEADBEEF);
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wr_gnt_latency got=%b exp=0000", gnt); end
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL wr_gnt got=%b exp=0001", gnt); end
        checks++; if (bus.s_cyc_o !== 4'b0010 || bus.s_we_o !== 4'b0010) begin
            errors++; $display("FAIL wr_s_cyc cyc=%b we=%b exp=0010", bus.s_cyc_o, bus.s_we_o); end
        checks++; if (bus.s_adr_o[1*AW +: AW] !== 20'h00004) begin
            errors++; $display("FAIL wr_s_adr got=%h exp=00004", bus.s_adr_o[1*AW +: AW]); end
        checks++; if (bus.s_dat_o[1*DW +: DW] !== 32'hDEADBEEF || bus.s_sel_o[1*SW +: SW] !== 4'hF) begin
            errors++; $display("FAIL wr_s_dat got=%h sel=%h exp=deadbeef f", bus.s_dat_o[1*DW +: DW], bus.s_sel_o[1*SW +: SW]); end
        for (int n = 1; n <= 10 && ack_at == 0; n++) begin
            if (n > 1) @(negedge clk);
            if (bus.s_stb_o !== 4'b0010) stray++;
            if (bus.m_ack_o !== 4'b0000) begin ack_at = n; ackv = bus.m_ack_o; end
        end
        checks++; if (ack_at != 3) begin errors++; $display("FAIL wr_ack_cycle got=%0d exp=3", ack_at); end
        checks++; if (ackv !== 4'b0001) begin errors++; $display("FAIL wr_ack_vec got=%b exp=0001", ackv); end
        checks++; if (stray != 0) begin errors++; $display("FAIL wr_stray_stb got=%0d exp=0", stray); end
        set_master(0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0000) begin errors++; $display("FAIL wr_ack_len got=%b exp=0000", bus.m_ack_o); end
        checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 4'b0000) begin
            errors++; $display("FAIL wr_release gnt=%b s_cyc=%b exp=0", gnt, bus.s_cyc_o); end
    endtask

    task automatic test_round_robin();
        logic [NM-1:0] order[$];
        logic [NM-1:0] prev, g, o0, o1, o2;
        int            rem[NM];
        int            gaps, midchg, stray, datbad, left;
        apply_reset();
        for (int k = 0; k < NS; k++) s_lat[k] = 1;
        rem = '{3, 3, 0, 3};
        gaps = 0; midchg = 0; stray = 0; datbad = 0; prev = '0; left = 9;
        set_master(0, 1'b1, 1'b0, 20'h00010, '0);
        set_master(1, 1'b1, 1'b0, 20'h10020, '0);
        set_master(3, 1'b1, 1'b0, 20'h30030, '0);
        for (int c = 0; c < 200 && left > 0; c++) begin
            @(negedge clk);
            g = gnt;
            if (g !== prev) begin
                for (int m = 0; m < NM; m++) if (prev[m] && rem[m] > 0) midchg++;
                if (g != 0) order.push_back(g);
            end
            if (g == 0 && order.size() > 0) gaps++;
            if ((bus.m_ack_o & ~g) != 0) stray++;
            for (int m = 0; m < NM; m++) begin
                if (rem[m] > 0 && bus.m_ack_o[m]) begin
                    if (bus.m_dat_o[m*DW +: DW] !== (32'hA5A50000 | 32'(m))) datbad++;
                    rem[m]--;
                    left--;
                    if (rem[m] == 0) set_master(m, 1'b0, 1'b0, '0, '0);
                end
            end
            prev = g;
        end
        @(negedge clk);
        o0 = (order.size() > 0) ? order[0] : 'x;
        o1 = (order.size() > 1) ? order[1] : 'x;
        o2 = (order.size() > 2) ? order[2] : 'x;
        checks++; if (left != 0) begin errors++; $display("FAIL rr_done remaining=%0d exp=0", left); end
        checks++; if (order.size() != 3) begin errors++; $display("FAIL rr_grants got=%0d exp=3", order.size()); end
        checks++; if (o0 !== 4'b0001 || o1 !== 4'b0010 || o2 !== 4'b1000) begin
            errors++; $display("FAIL rr_order got=%b,%b,%b exp=0001,0010,1000", o0, o1, o2); end
        checks++; if (gaps != 0) begin errors++; $display("FAIL rr_idle_gap got=%0d exp=0", gaps); end
        checks++; if (midchg != 0) begin errors++; $display("FAIL rr_mid_cyc_change got=%0d exp=0", midchg); end
        checks++; if (stray != 0) begin errors++; $display("FAIL rr_ack_to_ungranted got=%0d exp=0", stray); end
        checks++; if (datbad != 0) begin errors++; $display("FAIL rr_read_data bad=%0d exp=0", datbad); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rr_final_idle got=%b exp=0000", gnt); end
        // pointer wrapped past m3: m0 beats m1
        set_master(0, 1'b1, 1'b0, 20'h00010, '0);
        set_master(1, 1'b1, 1'b0, 20'h10020, '0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rr_wrap got=%b exp=0001", gnt); end
        idle_all();
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_decode_err();
        for (int k = 0; k < NS; k++) s_lat[k] = 1;
        set_master(2, 1'b1, 1'b0, 20'h70000, '0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL derr_gnt got=%b exp=0100", gnt); end
        checks++; if (bus.s_stb_o !== 4'b0000 || bus.s_cyc_o !== 4'b0000) begin
            errors++; $display("FAIL derr_no_strobe stb=%b cyc=%b exp=0", bus.s_stb_o, bus.s_cyc_o); end
        checks++; if (bus.m_err_o !== 4'b0000 || derr !== 1'b0) begin
            errors++; $display("FAIL derr_early err=%b pulse=%b exp=0", bus.m_err_o, derr); end
        @(negedge clk);
        checks++; if (bus.m_err_o !== 4'b0100 || derr !== 1'b1) begin
            errors++; $display("FAIL derr_pulse err=%b pulse=%b exp=0100 1", bus.m_err_o, derr); end
        checks++; if (bus.m_dat_o[2*DW +: DW] !== 32'h0 || bus.m_ack_o !== 4'b0000) begin
            errors++; $display("FAIL derr_data dat=%h ack=%b exp=0 0", bus.m_dat_o[2*DW +: DW], bus.m_ack_o); end
        set_master(2, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        checks++; if (bus.m_err_o !== 4'b0000 || derr !== 1'b0) begin
            errors++; $display("FAIL derr_len err=%b pulse=%b exp=0", bus.m_err_o, derr); end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int err_at, tmo_at, tmo_cnt, ack_at, err_cnt;
        logic [NS-1:0] stb15;
        // slave 3 silent
        s_lat[3] = 1000;
        err_at = 0; tmo_at = 0; tmo_cnt = 0; stb15 = '0;
        set_master(1, 1'b1, 1'b0, 20'h30000, '0);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (n == 15) stb15 = bus.s_stb_o;
            if (bus.m_err_o[1] && err_at == 0) err_at = n;
            if (tmo) begin tmo_cnt++; tmo_at = n; end
            if (bus.m_err_o !== 4'b0000 || bus.m_ack_o !== 4'b0000) set_master(1, 1'b0, 1'b0, '0, '0);
        end
        checks++; if (stb15 !== 4'b1000) begin errors++; $display("FAIL tmo_stb_held got=%b exp=1000", stb15); end
        checks++; if (err_at != 16) begin errors++; $display("FAIL tmo_err_cycle got=%0d exp=16", err_at); end
        checks++; if (tmo_at != 16 || tmo_cnt != 1) begin
            errors++; $display("FAIL tmo_pulse at=%0d count=%0d exp=16 1", tmo_at, tmo_cnt); end
        // slave 3 acks exactly on the timeout cycle
        s_lat[3] = 15;
        ack_at = 0; err_cnt = 0; tmo_cnt = 0;
        set_master(1, 1'b1, 1'b0, 20'h30000, '0);
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            if (bus.m_ack_o[1] && ack_at == 0) ack_at = n;
            if (bus.m_err_o !== 4'b0000) err_cnt++;
            if (tmo) tmo_cnt++;
            if (bus.m_err_o !== 4'b0000 || bus.m_ack_o !== 4'b0000) set_master(1, 1'b0, 1'b0, '0, '0);
        end
        checks++; if (ack_at != 16) begin errors++; $display("FAIL tmo_ack_cycle got=%0d exp=16", ack_at); end
        checks++; if (err_cnt != 0 || tmo_cnt != 0) begin
            errors++; $display("FAIL tmo_ack_wins err=%0d pulse=%0d exp=0 0", err_cnt, tmo_cnt); end
    endtask

    task automatic test_reset_mid();
        s_lat[0] = 2;
        set_master(0, 1'b1, 1'b1, 20'h00040, 32'h12345678);
        @(negedge clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_gnt got=%b exp=0001", gnt); end
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.m_ack_o !== 4'b0001) begin errors++; $display("FAIL rstmid_pre_ack got=%b exp=0001", bus.m_ack_o); end
        #2 rst = 1'b1;
        #1;
        checks++; if (gnt !== 4'b0000 || bus.s_cyc_o !== 4'b0000 || bus.m_ack_o !== 4'b0000) begin
            errors++; $display("FAIL rstmid_async gnt=%b s_cyc=%b ack=%b exp=0", gnt, bus.s_cyc_o, bus.m_ack_o); end
        idle_all();
        @(negedge clk);
        rst = 1'b0;
        set_master(1, 1'b1, 1'b0, 20'h10000, '0);
        set_master(3, 1'b1, 1'b0, 20'h30000, '0);
        @(negedge clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL rstmid_ptr got=%b exp=0010", gnt); end
        idle_all();
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < NS; k++) bus.s_dat_i[k*DW +: DW] = 32'hA5A50000 | 32'(k);
        idle_all();
        test_reset();
        test_single_write();
        test_round_robin();
        test_decode_err();
        test_timeout();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
